y86_seq_sequencer: RTL and testbench

Phase sequencer and status controller for the sequential Y86-64 core. It owns the architectural PC and the processor status register. It steps one instruction through six one-cycle phases (fetch, decode, execute, memory, writeback, PC update) by asserting per-stage enables, and stops on halt or error. It sits above `instruct_fetch`, `decode_write`, `execute`, `memory` and `pc_update`, and supplies them `pc_val`.

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/y86_seq_sequencer.sv | 127 ++++++++++++
 tb/tb_y86_seq_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, sequencer states, stage-enable bit indices and icodes.
// The sequencer's PAUSE state exists only when Y86_SINGLE_STEP_EN is defined.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StPcupd,
    StStop
`ifdef Y86_SINGLE_STEP_EN
    ,
    StPause
`endif
  } y86_state_e;

  localparam int unsigned StageFetch  = 0;
  localparam int unsigned StageDecode = 1;
  localparam int unsigned StageExec   = 2;
  localparam int unsigned StageMem    = 3;
  localparam int unsigned StageWb     = 4;
  localparam int unsigned StagePcupd  = 5;
  localparam int unsigned NumStages   = 6;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  function automatic logic is_phase(input y86_state_e st);
    return (st == StFetch) || (st == StDecode) || (st == StExec) ||
           (st == StMem) || (st == StWb) || (st == StPcupd);
  endfunction

endpackage

// File: rtl/y86_seq_sequencer.sv
// Six-phase instruction sequencer for the sequential Y86-64 core; owns PC, status and counters.
// Y86_SINGLE_STEP_EN adds a step input and a PAUSE state entered after every PC update.
module y86_seq_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
`ifdef Y86_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic        halt,
  input  logic        imem_error,
  input  logic        instr_err,
  input  logic        dmem_error,
  input  logic [63:0] pc_new,
  output logic [63:0] pc_val,
  output logic [5:0]  stage_en,
  output logic [2:0]  stat,
  output logic        running,
  output logic [31:0] retired,
  output logic [31:0] cycles
);

  y86_state_e  state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [63:0] pc_q;
  logic [31:0] retired_q;
  logic [31:0] cycles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // hold gates every transition and every error sample, so it wraps the whole decode.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (!hold) begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StFetch;
        end
        StFetch: begin
          if (imem_error) begin
            stat_d  = STAT_ADR;
            state_d = StStop;
          end else if (instr_err) begin
            stat_d  = STAT_INS;
            state_d = StStop;
          end else if (halt) begin
            stat_d  = STAT_HLT;
            state_d = StStop;
          end else begin
            state_d = StDecode;
          end
        end
        StDecode: state_d = StExec;
        StExec:   state_d = StMem;
        StMem: begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = StStop;
          end else begin
            state_d = StWb;
          end
        end
        StWb: state_d = StPcupd;
`ifdef Y86_SINGLE_STEP_EN
        StPcupd: state_d = StPause;
        StPause: begin
          if (step) state_d = StFetch;
        end
`else
        StPcupd: state_d = StFetch;
`endif
        StStop:  state_d = StStop;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q    <= STAT_AOK;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      stat_q <= stat_d;
      if (!hold && state_q == StPcupd) begin
        pc_q      <= pc_new;
        retired_q <= retired_q + 32'd1;
      end
      if (!hold && is_phase(state_q)) begin
        cycles_q <= cycles_q + 32'd1;
      end
    end
  end

  always_comb begin
    stage_en = '0;
    unique case (state_q)
      StFetch:  stage_en[StageFetch]  = 1'b1;
      StDecode: stage_en[StageDecode] = 1'b1;
      StExec:   stage_en[StageExec]   = 1'b1;
      StMem:    stage_en[StageMem]    = 1'b1;
      StWb:     stage_en[StageWb]     = 1'b1;
      StPcupd:  stage_en[StagePcupd]  = 1'b1;
      default:  stage_en = '0;
    endcase
    running = is_phase(state_q);
  end

  assign pc_val  = pc_q;
  assign stat    = stat_q;
  assign retired = retired_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Directed bench for y86_seq_sequencer; set Y86_SINGLE_STEP_EN to also cover the PAUSE state.
module tb_y86_seq_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        halt = 1'b0;
  logic        imem_error = 1'b0;
  logic        instr_err = 1'b0;
  logic        dmem_error = 1'b0;
  logic [63:0] pc_new = 64'd0;
  logic [63:0] pc_val;
  logic [5:0]  stage_en;
  logic [2:0]  stat;
  logic        running;
  logic [31:0] retired;
  logic [31:0] cycles;
`ifdef Y86_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int passed = 0;
  int total = 0;

  y86_seq_sequencer #(.RESET_PC(64'd0)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .hold       (hold),
`ifdef Y86_SINGLE_STEP_EN
    .step       (step),
`endif
    .halt       (halt),
    .imem_error (imem_error),
    .instr_err  (instr_err),
    .dmem_error (dmem_error),
    .pc_new     (pc_new),
    .pc_val     (pc_val),
    .stage_en   (stage_en),
    .stat       (stat),
    .running    (running),
    .retired    (retired),
    .cycles     (cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Leave PCUPD; in single-step builds also pass through PAUSE with one step pulse.
  task automatic pcupd_exit();
    tick();
`ifdef Y86_SINGLE_STEP_EN
    chk("pause_stage_en", 64'(stage_en), 64'd0);
    chk("pause_running", 64'(running), 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_pc;
    logic [5:0]  one;
    int          nclk;

    // Reset state
    tick();
    reset = 1'b0;
    chk("rst_pc", pc_val, 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_stage_en", 64'(stage_en), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);

    // Three clean instructions
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 64'd0;
    one = 6'd1;
    for (int i = 0; i < 3; i++) begin
      pc_new = exp_pc + 64'd10;
      for (int k = 0; k < 5; k++) begin
        chk("seq_stage_en", 64'(stage_en), 64'(one << k));
        chk("seq_running", 64'(running), 64'd1);
        tick();
      end
      chk("seq_stage_en_pcupd", 64'(stage_en), 64'd32);
      chk("seq_pc_before_commit", pc_val, exp_pc);
      pcupd_exit();
      exp_pc = exp_pc + 64'd10;
      chk("seq_pc", pc_val, exp_pc);
    end
    chk("seq_retired", 64'(retired), 64'd3);
    chk("seq_cycles", 64'(cycles), 64'd18);
    chk("seq_next_fetch", 64'(stage_en), 64'd1);

    // halt in first FETCH
    begin_run();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_stat", 64'(stat), 64'd2);
    chk("halt_pc", pc_val, 64'd0);
    chk("halt_retired", 64'(retired), 64'd0);
    chk("halt_stage_en", 64'(stage_en), 64'd0);
    chk("halt_running", 64'(running), 64'd0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("halt_stage_en_later", 64'(stage_en), 64'd0);
    chk("halt_stat_later", 64'(stat), 64'd2);
    chk("halt_cycles", 64'(cycles), 64'd1);

    // Fetch error priority
    begin_run();
    imem_error = 1'b1;
    instr_err = 1'b1;
    tick();
    imem_error = 1'b0;
    instr_err = 1'b0;
    chk("prio_imem_over_ins", 64'(stat), 64'd3);
    begin_run();
    instr_err = 1'b1;
    halt = 1'b1;
    tick();
    instr_err = 1'b0;
    halt = 1'b0;
    chk("prio_ins_over_halt", 64'(stat), 64'd4);

    // hold masks an error sample in FETCH
    begin_run();
    hold = 1'b1;
    imem_error = 1'b1;
    tick();
    chk("hold_fetch_stage_en", 64'(stage_en), 64'd1);
    chk("hold_fetch_stat", 64'(stat), 64'd1);
    chk("hold_fetch_cycles", 64'(cycles), 64'd0);
    hold = 1'b0;
    tick();
    imem_error = 1'b0;
    chk("hold_release_stat", 64'(stat), 64'd3);

    // dmem_error in MEM of second instruction
    begin_run();
    pc_new = 64'd10;
    repeat (5) tick();
    pcupd_exit();
    chk("dmem_pc_first", pc_val, 64'd10);
    pc_new = 64'd20;
    repeat (3) tick();
    chk("dmem_in_mem", 64'(stage_en), 64'd8);
    dmem_error = 1'b1;
    tick();
    dmem_error = 1'b0;
    chk("dmem_stat", 64'(stat), 64'd3);
    chk("dmem_stage_en", 64'(stage_en), 64'd0);
    repeat (3) tick();
    chk("dmem_pc", pc_val, 64'd10);
    chk("dmem_retired", 64'(retired), 64'd1);
    chk("dmem_cycles", 64'(cycles), 64'd10);

    // hold for 4 cycles in EXEC
    begin_run();
    pc_new = 64'd10;
    nclk = 0;
    repeat (2) begin tick(); nclk++; end
    chk("hold_exec_entry", 64'(stage_en), 64'd4);
    hold = 1'b1;
    repeat (4) begin
      tick();
      nclk++;
      chk("hold_exec_stage_en", 64'(stage_en), 64'd4);
    end
    chk("hold_exec_cycles", 64'(cycles), 64'd2);
    hold = 1'b0;
    repeat (3) begin tick(); nclk++; end
    chk("hold_pcupd", 64'(stage_en), 64'd32);
    tick();
    nclk++;
    chk("hold_total_clocks", 64'(nclk), 64'd10);
    chk("hold_pc", pc_val, 64'd10);
    chk("hold_retired", 64'(retired), 64'd1);
    chk("hold_cycles", 64'(cycles), 64'd6);

    // start together with reset stays in IDLE
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_stage_en", 64'(stage_en), 64'd0);
    tick();
    chk("rst_start_idle", 64'(stage_en), 64'd0);
    chk("rst_start_pc", pc_val, 64'd0);

`ifdef Y86_SINGLE_STEP_EN
    begin_run();
    pc_new = 64'd10;
    repeat (6) tick();
    chk("ss_pause_stage_en", 64'(stage_en), 64'd0);
    chk("ss_pause_retired", 64'(retired), 64'd1);
    tick();
    chk("ss_pause_holds", 64'(running), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ss_reset_retired", 64'(retired), 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("ss_idle_ignores_step", 64'(stage_en), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ss_restart_fetch", 64'(stage_en), 64'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
